branch_predictor: RTL

Fetch-stage dynamic branch predictor with a direct-mapped branch target buffer (BTB) and 2-bit saturating counters. It gives the IF stage a next-PC prediction in the same cycle. It takes branch/jump resolutions from EX, where `pc_sel` from the branch controller is the actual outcome. It raises a mispredict flush/redirect and updates its tables on the following clock edge.

---
 rtl/branch_predictor.sv | 114 +++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit counters,
// EX-stage resolve/redirect and saturating performance counters.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int INDEX_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  if_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic             ex_taken,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int TAG_W   = XLEN - INDEX_W - 2;
  localparam logic [XLEN-1:0]  STEP  = XLEN'(4);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SAT   = {CNT_W{1'b1}};

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] jmp_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];
  logic [1:0]         cnt_q [ENTRIES];

  logic [INDEX_W-1:0] l_idx;
  logic [INDEX_W-1:0] u_idx;
  logic [TAG_W-1:0]   l_tag;
  logic [TAG_W-1:0]   u_tag;
  logic               l_hit;
  logic               u_hit;
  logic               res;
  logic               wrong;
  logic               unused_bits;

  assign l_idx = if_pc[INDEX_W+1:2];
  assign l_tag = if_pc[XLEN-1:INDEX_W+2];
  assign u_idx = ex_pc[INDEX_W+1:2];
  assign u_tag = ex_pc[XLEN-1:INDEX_W+2];

  assign unused_bits = ^{if_pc[1:0], ex_pc[1:0]};

  // Lookup reads registered state only, so a same-cycle update is not seen.
  assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign pred_taken = l_hit && (jmp_q[l_idx] || cnt_q[l_idx][1]);
  assign pred_target = pred_taken ? tgt_q[l_idx] : if_pc + STEP;

  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign res   = ex_valid && (ex_is_branch || ex_is_jump);
  assign wrong = (ex_taken != ex_pred_taken) ||
                 (ex_taken && (ex_target != ex_pred_target));

  assign mispredict  = !reset && res && wrong;
  assign redirect_pc = ex_taken ? ex_target : ex_pc + STEP;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        jmp_q[i]   <= 1'b0;
        cnt_q[i]   <= 2'b01;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
      end
    end else if (res) begin
      if (u_hit) begin
        if (ex_is_jump) begin
          cnt_q[u_idx] <= 2'd3;
          jmp_q[u_idx] <= 1'b1;
          tgt_q[u_idx] <= ex_target;
        end else if (ex_taken) begin
          if (cnt_q[u_idx] != 2'd3)
            cnt_q[u_idx] <= cnt_q[u_idx] + 2'd1;
          tgt_q[u_idx] <= ex_target;
        end else if (cnt_q[u_idx] != 2'd0) begin
          cnt_q[u_idx] <= cnt_q[u_idx] - 2'd1;
        end
      end else if (ex_taken) begin
        // Allocation overwrites whatever alias lives at this index.
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= ex_target;
        jmp_q[u_idx]   <= ex_is_jump;
        cnt_q[u_idx]   <= ex_is_jump ? 2'd3 : 2'd2;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (res && (br_count != SAT))
        br_count <= br_count + ONE;
      if (mispredict && (mispred_count != SAT))
        mispred_count <= mispred_count + ONE;
    end
  end

endmodule
